// File: rtl/mem_lsu_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
// Request phase: req/we/addr/wdata/wstrb are held until gnt.
// Response phase: rvalid/rdata return read data after the grant.
interface mem_lsu_if #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [XLEN-1:0]       wdata;
  logic [XLEN/8-1:0]     wstrb;
  logic                  gnt;
  logic                  rvalid;
  logic [XLEN-1:0]       rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit for RV32/RV64.
// Non-memory ops pass through to MEM_WB one cycle after acceptance. Loads and
// stores go out over a req/gnt/rvalid bus while the pipeline is stalled.
// Optional feature macro: LSU_MISALIGN_EXC_EN -- misaligned H/W/D accesses raise
// a one-cycle exc_o pulse instead of accessing memory. Without it, misaligned
// accesses are aligned down and exc_o stays 0.
//
// state  | meaning
// IDLE   | ready; accepts the EXE_MEM slot whenever valid_i is high
// REQ    | bus request held until the memory grants it
// WAIT   | load granted, waiting for rvalid
module mem_lsu #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] alu_val_i,
  input  logic [XLEN-1:0] rs2_val_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            rd_we_i,
  input  logic            mem_re_i,
  input  logic            mem_we_i,
  input  logic [2:0]      mem_mode_i,
  output logic            stall_o,
  mem_lsu_if.master       bus,
  output logic            valid_o,
  output logic [XLEN-1:0] rd_val_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_we_o,
  output logic            exc_o
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  // Access width; SZ_F is a full-XLEN access (LW on RV32, LD/SD, undefined funct3).
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_F} size_t;

  state_t state_q, state_d;

  size_t           in_size;
  logic            in_sext;
  logic [OFFW-1:0] off_raw;
  logic [OFFW-1:0] off_al;
  logic [XLEN-1:0] in_wdata;
  logic [NB-1:0]   in_wstrb;
  logic            is_mem;
  logic            accept;
  logic            mis_exc;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [XLEN-1:0]       wdata_q;
  logic [NB-1:0]         wstrb_q;
  logic                  we_q;
  size_t                 size_q;
  logic                  sext_q;
  logic [OFFW-1:0]       off_q;
  logic [4:0]            rd_addr_q;
  logic                  rd_we_q;

  logic [XLEN-1:0] rdata_sh;
  logic [XLEN-1:0] load_val;

  assign is_mem  = mem_re_i | mem_we_i;
  assign accept  = (state_q == S_IDLE) & valid_i;
  assign off_raw = alu_val_i[OFFW-1:0];

  // Decode funct3 into access width and signedness; load wins when both re and we are set.
  always_comb begin
    in_size = SZ_F;
    in_sext = 1'b0;
    case (mem_mode_i)
      3'b000: begin in_size = SZ_B; in_sext = 1'b1; end
      3'b001: begin in_size = SZ_H; in_sext = 1'b1; end
      3'b010: begin in_size = (XLEN == 64) ? SZ_W : SZ_F; in_sext = 1'b1; end
      3'b100: in_size = mem_re_i ? SZ_B : SZ_F;
      3'b101: in_size = mem_re_i ? SZ_H : SZ_F;
      3'b110: in_size = (mem_re_i && XLEN == 64) ? SZ_W : SZ_F;
      default: in_size = SZ_F;
    endcase
  end

  // Byte-lane offset with the low bits that break natural alignment cleared.
  always_comb begin
    off_al = off_raw;
    case (in_size)
      SZ_B:    off_al = off_raw;
      SZ_H:    off_al = off_raw & ~OFFW'(1);
      SZ_W:    off_al = off_raw & ~OFFW'(3);
      default: off_al = '0;
    endcase
  end

  // Replicate store data across lanes and build the byte strobes.
  always_comb begin
    in_wdata = rs2_val_i;
    in_wstrb = '1;
    case (in_size)
      SZ_B: begin in_wdata = {NB{rs2_val_i[7:0]}};       in_wstrb = NB'(1)  << off_al; end
      SZ_H: begin in_wdata = {(NB/2){rs2_val_i[15:0]}};  in_wstrb = NB'(3)  << off_al; end
      SZ_W: begin in_wdata = {(NB/4){rs2_val_i[31:0]}};  in_wstrb = NB'(15) << off_al; end
      default: ;
    endcase
    if (mem_re_i) in_wstrb = '0;
  end

`ifdef LSU_MISALIGN_EXC_EN
  logic in_chk;

  // Only defined H/W/D encodings are alignment-checked; undefined ones are full-width accesses.
  always_comb begin
    in_chk = 1'b0;
    case (mem_mode_i)
      3'b001, 3'b010: in_chk = 1'b1;
      3'b011:         in_chk = (XLEN == 64);
      3'b101:         in_chk = mem_re_i;
      3'b110:         in_chk = mem_re_i && (XLEN == 64);
      default:        in_chk = 1'b0;
    endcase
  end

  assign mis_exc = is_mem & in_chk & (off_al != off_raw);
`else
  assign mis_exc = 1'b0;
`endif

  assign stall_o = (state_q != S_IDLE) | (accept & is_mem & ~mis_exc);

  assign bus.req   = (state_q == S_REQ);
  assign bus.we    = we_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
  assign bus.wstrb = wstrb_q;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_mem && !mis_exc) state_d = S_REQ;
      S_REQ:   if (bus.gnt) state_d = we_q ? S_IDLE : S_WAIT;
      S_WAIT:  if (bus.rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Shift the addressed lane down and extend to XLEN.
  always_comb begin
    rdata_sh = bus.rdata >> {off_q, 3'b000};
    case (size_q)
      SZ_B:    load_val = sext_q ? XLEN'($signed(rdata_sh[7:0]))  : XLEN'(rdata_sh[7:0]);
      SZ_H:    load_val = sext_q ? XLEN'($signed(rdata_sh[15:0])) : XLEN'(rdata_sh[15:0]);
      SZ_W:    load_val = sext_q ? XLEN'($signed(rdata_sh[31:0])) : XLEN'(rdata_sh[31:0]);
      default: load_val = rdata_sh;
    endcase
  end

  // Capture the access on accept and produce the one-cycle MEM_WB pulse on completion.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      we_q      <= 1'b0;
      size_q    <= SZ_B;
      sext_q    <= 1'b0;
      off_q     <= '0;
      rd_addr_q <= '0;
      rd_we_q   <= 1'b0;
      valid_o   <= 1'b0;
      rd_val_o  <= '0;
      rd_addr_o <= '0;
      rd_we_o   <= 1'b0;
      exc_o     <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      exc_o   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (valid_i) begin
            if (!is_mem) begin
              valid_o   <= 1'b1;
              rd_val_o  <= alu_val_i;
              rd_addr_o <= rd_addr_i;
              rd_we_o   <= rd_we_i & (rd_addr_i != 5'd0);
            end else if (mis_exc) begin
              exc_o     <= 1'b1;
              rd_val_o  <= '0;
              rd_addr_o <= rd_addr_i;
              rd_we_o   <= 1'b0;
            end else begin
              addr_q    <= alu_val_i[ADDR_WIDTH-1:0] & ~ADDR_WIDTH'(NB - 1);
              wdata_q   <= in_wdata;
              wstrb_q   <= in_wstrb;
              we_q      <= ~mem_re_i;
              size_q    <= in_size;
              sext_q    <= in_sext;
              off_q     <= off_al;
              rd_addr_q <= rd_addr_i;
              rd_we_q   <= rd_we_i;
            end
          end
        end
        S_REQ: begin
          if (bus.gnt && we_q) begin
            valid_o   <= 1'b1;
            rd_val_o  <= '0;
            rd_addr_o <= rd_addr_q;
            rd_we_o   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.rvalid) begin
            valid_o   <= 1'b1;
            rd_val_o  <= load_val;
            rd_addr_o <= rd_addr_q;
            rd_we_o   <= rd_we_q & (rd_addr_q != 5'd0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu (RV32 build). The driver issues instructions and
// plays the memory; for each cycle it states what the outputs must be, derived
// from byte-level arithmetic on the access, and one compare process checks them.
module tb_mem_lsu;
  localparam int XLEN = 32;
  localparam int AW   = 32;
  localparam int NB   = XLEN / 8;
`ifdef LSU_MISALIGN_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_i;
  logic valid_i, rd_we_i, mem_re_i, mem_we_i;
  logic [XLEN-1:0] alu_val_i, rs2_val_i;
  logic [4:0] rd_addr_i;
  logic [2:0] mem_mode_i;
  logic stall_o, valid_o, rd_we_o, exc_o;
  logic [XLEN-1:0] rd_val_o;
  logic [4:0] rd_addr_o;

  mem_lsu_if #(.XLEN(XLEN), .ADDR_WIDTH(AW)) bus_if ();

  mem_lsu #(.XLEN(XLEN), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .alu_val_i(alu_val_i),
    .rs2_val_i(rs2_val_i), .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i),
    .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .mem_mode_i(mem_mode_i),
    .stall_o(stall_o), .bus(bus_if), .valid_o(valid_o), .rd_val_o(rd_val_o),
    .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o), .exc_o(exc_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  // Expectations for the current cycle, and those due next cycle.
  bit exp_stall, exp_req, exp_bw, exp_valid, exp_exc, exp_we, exp_chk_val, exp_rst_zero;
  logic [AW-1:0]   exp_addr;
  logic [XLEN-1:0] exp_wdata, exp_val;
  logic [NB-1:0]   exp_wstrb;
  logic [4:0]      exp_rd;
  bit pend_valid, pend_exc, pend_we, pend_chk_val;
  logic [XLEN-1:0] pend_val;
  logic [4:0]      pend_rd;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] rnd();
    return XLEN'({$urandom, $urandom});
  endfunction

  // ---------------- reference model (byte arithmetic) ----------------
  function automatic int m_size(input logic [2:0] f, input bit ld);
    case (f)
      3'd0: return 1;
      3'd1: return 2;
      3'd2: return 4;
      3'd4: return ld ? 1 : NB;
      3'd5: return ld ? 2 : NB;
      3'd6: return (ld && XLEN == 64) ? 4 : NB;
      default: return NB;
    endcase
  endfunction

  function automatic bit m_checked(input logic [2:0] f, input bit ld);
    return (f == 3'd1) || (f == 3'd2) || (f == 3'd3 && XLEN == 64) ||
           (ld && f == 3'd5) || (ld && f == 3'd6 && XLEN == 64);
  endfunction

  function automatic int m_off(input logic [XLEN-1:0] a, input logic [2:0] f, input bit ld);
    int raw;
    int sz;
    raw = int'(a % NB);
    sz  = m_size(f, ld);
    return raw - (raw % sz);
  endfunction

  function automatic bit m_misaligned(input logic [XLEN-1:0] a, input logic [2:0] f, input bit ld);
    return m_checked(f, ld) && ((int'(a % NB) % m_size(f, ld)) != 0);
  endfunction

  function automatic logic [AW-1:0] m_addr(input logic [XLEN-1:0] a);
    return AW'(a - (a % NB));
  endfunction

  function automatic logic [NB-1:0] m_strb(input logic [XLEN-1:0] a, input logic [2:0] f, input bit ld);
    logic [NB-1:0] s;
    int off;
    int sz;
    s = '0;
    off = m_off(a, f, ld);
    sz  = m_size(f, ld);
    if (!ld)
      for (int b = 0; b < NB; b++)
        if (b >= off && b < off + sz) s[b] = 1'b1;
    return s;
  endfunction

  function automatic logic [XLEN-1:0] m_wdata(input logic [XLEN-1:0] d, input logic [2:0] f, input bit ld);
    logic [XLEN-1:0] w;
    int sz;
    sz = m_size(f, ld);
    for (int b = 0; b < NB; b++) w[8*b +: 8] = d[8*(b % sz) +: 8];
    return w;
  endfunction

  function automatic logic [XLEN-1:0] m_load(input logic [XLEN-1:0] rdat, input logic [XLEN-1:0] a,
                                             input logic [2:0] f);
    logic [63:0] v;
    logic [63:0] mask;
    int sz;
    int off;
    sz  = m_size(f, 1'b1);
    off = m_off(a, f, 1'b1);
    v = 64'(rdat) >> (8 * off);
    if (sz < NB) begin
      mask = (64'd1 << (8 * sz)) - 64'd1;
      v = v & mask;
      if (f < 3'd3 && v[8*sz-1]) v = v | ~mask;
    end
    return v[XLEN-1:0];
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (check_en) begin
      check("stall_o", stall_o, exp_stall);
      check("req_o", bus_if.req, exp_req);
      check("valid_o", valid_o, exp_valid);
      check("exc_o", exc_o, exp_exc);
      if (exp_req) begin
        check("addr_o", bus_if.addr, exp_addr);
        check("we_o", bus_if.we, exp_bw);
        check("wstrb_o", bus_if.wstrb, exp_wstrb);
        if (exp_bw) check("wdata_o", bus_if.wdata, exp_wdata);
      end
      if (exp_valid) check("rd_addr_o", rd_addr_o, exp_rd);
      if (exp_valid || exp_exc) check("rd_we_o", rd_we_o, exp_we);
      if (exp_valid && exp_chk_val) check("rd_val_o", rd_val_o, exp_val);
      if (exp_rst_zero) begin
        check("rst rd_val_o", rd_val_o, 0);
        check("rst rd_addr_o", rd_addr_o, 0);
        check("rst rd_we_o", rd_we_o, 0);
        check("rst we_o", bus_if.we, 0);
        check("rst addr_o", bus_if.addr, 0);
        check("rst wdata_o", bus_if.wdata, 0);
        check("rst wstrb_o", bus_if.wstrb, 0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic next_cycle();
    @(posedge clk);
    #2;
    exp_valid = pend_valid; exp_exc = pend_exc; exp_val = pend_val;
    exp_rd = pend_rd; exp_we = pend_we; exp_chk_val = pend_chk_val;
    pend_valid = 0; pend_exc = 0; pend_we = 0; pend_chk_val = 0;
    exp_stall = 0; exp_req = 0; exp_rst_zero = 0;
    valid_i = 0; mem_re_i = 0; mem_we_i = 0;
    alu_val_i = rnd(); rs2_val_i = rnd(); rd_addr_i = 5'($urandom);
    rd_we_i = 1'($urandom); mem_mode_i = 3'($urandom);
    bus_if.gnt = 1'($urandom); bus_if.rvalid = 1'($urandom); bus_if.rdata = rnd();
  endtask

  // kind: 0 ALU, 1 load, 2 store. gd/vd: cycles before gnt / rvalid.
  task automatic issue(input int kind, input logic [2:0] f3, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] d, input logic [4:0] rd, input bit we,
                       input int gd, input int vd, input logic [XLEN-1:0] rdat);
    bit ld;
    ld = (kind == 1);
    valid_i = 1; alu_val_i = a; rs2_val_i = d; rd_addr_i = rd; rd_we_i = we; mem_mode_i = f3;
    mem_re_i = ld;
    mem_we_i = (kind == 2) || (ld && $urandom_range(0, 1) == 1);
    if (kind == 0) begin
      pend_valid = 1; pend_val = a; pend_rd = rd; pend_we = we && (rd != 0); pend_chk_val = 1;
      next_cycle();
      return;
    end
    if (EXC_EN && m_misaligned(a, f3, ld)) begin
      pend_exc = 1; pend_we = 0;
      next_cycle();
      return;
    end
    exp_stall = 1;
    next_cycle();
    for (int i = 0; i <= gd; i++) begin
      exp_stall = 1; exp_req = 1; exp_bw = !ld; exp_addr = m_addr(a);
      exp_wstrb = m_strb(a, f3, ld); exp_wdata = m_wdata(d, f3, ld);
      valid_i = 1'($urandom); mem_re_i = 1'($urandom);
      bus_if.gnt = (i == gd);
      if (i == gd && !ld) begin pend_valid = 1; pend_rd = rd; pend_we = 0; end
      next_cycle();
    end
    if (ld) begin
      for (int j = 0; j <= vd; j++) begin
        exp_stall = 1;
        valid_i = 1'($urandom); mem_we_i = 1'($urandom);
        bus_if.rvalid = (j == vd);
        if (j == vd) begin
          bus_if.rdata = rdat;
          pend_valid = 1; pend_val = m_load(rdat, a, f3); pend_rd = rd;
          pend_we = we && (rd != 0); pend_chk_val = 1;
        end
        next_cycle();
      end
    end
  endtask

  // Reset during REQ (in_wait=0) or WAIT (in_wait=1); the late bus response must be ignored.
  task automatic reset_mid(input bit in_wait);
    valid_i = 1; mem_re_i = 1; mem_we_i = 0; mem_mode_i = 3'd2;
    alu_val_i = 32'h40; rd_addr_i = 5'd3; rd_we_i = 1;
    exp_stall = 1;
    next_cycle();
    exp_stall = 1; exp_req = 1; exp_bw = 0; exp_addr = m_addr(32'h40); exp_wstrb = '0;
    bus_if.gnt = in_wait; rst_i = !in_wait;
    next_cycle();
    if (in_wait) begin
      exp_stall = 1; bus_if.rvalid = 0; rst_i = 1;
      next_cycle();
    end
    rst_i = 0; bus_if.rvalid = 1; bus_if.gnt = 1; exp_rst_zero = 1;
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    pend_valid = 0; pend_exc = 0; pend_we = 0; pend_chk_val = 0; pend_val = '0; pend_rd = '0;
    exp_stall = 0; exp_req = 0; exp_bw = 0; exp_valid = 0; exp_exc = 0; exp_we = 0;
    exp_chk_val = 0; exp_rst_zero = 0; exp_addr = '0; exp_wdata = '0; exp_val = '0;
    exp_wstrb = '0; exp_rd = '0;
    rst_i = 1; valid_i = 0; mem_re_i = 0; mem_we_i = 0; rd_we_i = 0;
    alu_val_i = '0; rs2_val_i = '0; rd_addr_i = '0; mem_mode_i = '0;
    bus_if.gnt = 0; bus_if.rvalid = 0; bus_if.rdata = '0;

    // Pin the model against hand-computed values.
    check("model LB", m_load(32'h80000000, 32'h1003, 3'd0), 32'hFFFFFF80);
    check("model LBU", m_load(32'h80000000, 32'h1003, 3'd4), 32'h00000080);
    check("model LH", m_load(32'h12348765, 32'h0, 3'd1), 32'hFFFF8765);
    check("model SH strb", m_strb(32'h2002, 3'd1, 1'b0), 4'b1100);
    check("model SH wdata", m_wdata(32'h0000ABCD, 3'd1, 1'b0), 32'hABCDABCD);
    check("model SH addr", m_addr(32'h2002), 32'h2000);
    check("model LW mis addr", m_addr(32'h1001), 32'h1000);

    next_cycle();
    rst_i = 1; check_en = 1; exp_rst_zero = 1;
    next_cycle();
    rst_i = 0; exp_rst_zero = 1;
    next_cycle();

    issue(0, 3'd0, 32'h1234, 32'h0, 5'd5, 1'b1, 0, 0, 32'h0);
    issue(1, 3'd0, 32'h1003, rnd(), 5'd7, 1'b1, 0, 0, 32'h80000000);
    issue(1, 3'd4, 32'h1003, rnd(), 5'd8, 1'b1, 0, 0, 32'h80000000);
    issue(2, 3'd1, 32'h2002, 32'h0000ABCD, 5'd9, 1'b1, 0, 0, 32'h0);
    issue(1, 3'd2, 32'h3000, rnd(), 5'd10, 1'b1, 3, 2, 32'hDEADBEEF);
    issue(1, 3'd2, 32'h1001, rnd(), 5'd11, 1'b1, 0, 0, 32'hCAFEF00D);
    issue(0, 3'd0, 32'h5555, 32'h0, 5'd0, 1'b1, 0, 0, 32'h0);
    issue(0, 3'd0, 32'h1111, 32'h0, 5'd1, 1'b1, 0, 0, 32'h0);
    issue(0, 3'd0, 32'h2222, 32'h0, 5'd2, 1'b0, 0, 0, 32'h0);
    reset_mid(1'b1);
    issue(0, 3'd0, 32'h00C0FFEE, 32'h0, 5'd12, 1'b1, 0, 0, 32'h0);
    reset_mid(1'b0);
    issue(0, 3'd0, 32'h0BADF00D, 32'h0, 5'd13, 1'b1, 0, 0, 32'h0);

    for (int n = 0; n < 400; n++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      issue($urandom_range(0, 2), 3'($urandom), rnd(), rnd(), rd, 1'($urandom),
            $urandom_range(0, 3), $urandom_range(0, 3), rnd());
      if ($urandom_range(0, 3) == 0) next_cycle();
    end

    next_cycle();
    next_cycle();
    check_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
